mem_port_arbiter: RTL and testbench

- Sequences and shares the single byte-wide RAM/IO port between two requesters: the instruction fetch unit (IF) and the load/store buffer (LS).
- Accepts whole-access requests of 1, 2 or 4 bytes, expands each into little-endian byte cycles, assembles read data and returns a one-cycle done pulse.
- Arbitrates round-robin, stalls IO stores on io_buffer_full, and cancels speculative work on flush.

---
 rtl/mem_port_arbiter_if.sv | 49 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch unit, load/store buffer, byte-wide RAM/IO port and the arbiter.
// slave is the arbiter side; master is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              rdy;
    logic              flush;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic              if_done;
    logic [31:0]       if_data;

    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ready;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              io_full;

    modport slave (
        input  rdy, flush,
        input  if_req, if_addr,
        output if_ready, if_done, if_data,
        input  ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        output ls_ready, ls_done, ls_rdata,
        output ram_we, ram_a, ram_dout,
        input  ram_din, io_full
    );

    modport master (
        output rdy, flush,
        output if_req, if_addr,
        input  if_ready, if_done, if_data,
        output ls_req, ls_we, ls_size, ls_addr, ls_wdata,
        input  ls_ready, ls_done, ls_rdata,
        input  ram_we, ram_a, ram_dout,
        output ram_din, io_full
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM/IO port between instruction fetch and load/store,
// expanding 1/2/4-byte accesses into little-endian byte cycles.
module mem_port_arbiter #(
    parameter int                ADDR_W  = 32,
    parameter logic [ADDR_W-1:0] IO_MASK = ADDR_W'(32'h0003_0000)
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    // state | meaning
    // IDLE  | no transfer in flight, requests may be granted
    // RD    | byte reads; cnt 0..N, edge N captures the last byte and finishes
    // WR    | byte writes; cnt 0..N, edge N issues the done pulse
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t            state;
    logic [2:0]        cnt;
    logic [2:0]        nbytes;
    logic              last_ls;
    logic              cur_ls;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rbuf;
    logic [31:0]       rbuf_nxt;
    logic              ram_we_q;
    logic              accept;
    logic              pick_ls;
    logic              is_io;
    logic [1:0]        cap_idx;
    logic [7:0]        wbyte;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign accept       = (state == IDLE) && bus.rdy && !bus.flush && !rst;
    assign bus.if_ready = accept;
    assign bus.ls_ready = accept;
    assign bus.ram_we   = ram_we_q && bus.rdy;

    // With both requesting, the side that did not win last time goes first.
    assign pick_ls = bus.ls_req && (!bus.if_req || !last_ls);
    assign is_io   = (addr & IO_MASK) == IO_MASK;
    assign cap_idx = cnt[1:0] - 2'd1;
    assign wbyte   = wdata[{cnt[1:0], 3'b000} +: 8];

    // ram_din belongs to the address presented in the previous cycle, i.e. byte cnt-1.
    always_comb begin
        rbuf_nxt = rbuf;
        rbuf_nxt[{cap_idx, 3'b000} +: 8] = bus.ram_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            nbytes       <= '0;
            last_ls      <= 1'b0;
            cur_ls       <= 1'b0;
            addr         <= '0;
            wdata        <= '0;
            rbuf         <= '0;
            ram_we_q     <= 1'b0;
            bus.if_done  <= 1'b0;
            bus.ls_done  <= 1'b0;
            bus.if_data  <= '0;
            bus.ls_rdata <= '0;
            bus.ram_a    <= '0;
            bus.ram_dout <= '0;
        end else if (bus.rdy) begin
            bus.if_done <= 1'b0;
            bus.ls_done <= 1'b0;
            case (state)
                IDLE: begin
                    ram_we_q  <= 1'b0;
                    bus.ram_a <= '0;
                    if (!bus.flush && (bus.if_req || bus.ls_req)) begin
                        state   <= (pick_ls && bus.ls_we) ? WR : RD;
                        cnt     <= '0;
                        cur_ls  <= pick_ls;
                        last_ls <= pick_ls;
                        addr    <= pick_ls ? bus.ls_addr : bus.if_addr;
                        nbytes  <= pick_ls ? size_bytes(bus.ls_size) : 3'd4;
                        wdata   <= bus.ls_wdata;
                        rbuf    <= '0;
                    end
                end
                RD: begin
                    ram_we_q <= 1'b0;
                    if (bus.flush) begin
                        state     <= IDLE;
                        bus.ram_a <= '0;
                    end else if (cnt == nbytes) begin
                        state     <= IDLE;
                        bus.ram_a <= '0;
                        if (cur_ls) begin
                            bus.ls_done  <= 1'b1;
                            bus.ls_rdata <= rbuf_nxt;
                        end else begin
                            bus.if_done <= 1'b1;
                            bus.if_data <= rbuf_nxt;
                        end
                    end else begin
                        bus.ram_a <= addr + ADDR_W'(cnt);
                        if (cnt != 3'd0) rbuf <= rbuf_nxt;
                        cnt <= cnt + 3'd1;
                    end
                end
                WR: begin
                    // Stores are already committed, so flush is deliberately ignored here.
                    if (cnt == nbytes) begin
                        ram_we_q    <= 1'b0;
                        bus.ram_a   <= '0;
                        bus.ls_done <= 1'b1;
                        state       <= IDLE;
                    end else if (is_io && bus.io_full) begin
                        ram_we_q  <= 1'b0;
                        bus.ram_a <= '0;
                    end else begin
                        ram_we_q     <= 1'b1;
                        bus.ram_a    <= addr + ADDR_W'(cnt);
                        bus.ram_dout <= wbyte;
                        cnt          <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    localparam logic [31:0] IO_MASK = 32'h0003_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_tests;
    int   n_fail;
    bit   m_last_ls;

    logic [7:0]  ram  [0:4095];
    logic [7:0]  mmem [0:4095];
    logic [31:0] obs_a[$];
    logic [7:0]  obs_d[$];

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .IO_MASK(IO_MASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] idx(input logic [31:0] a);
        return {a[17:16], a[9:0]};
    endfunction

    assign bus.ram_din = ram[idx(bus.ram_a)];

    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram[idx(bus.ram_a)] = bus.ram_dout;
            obs_a.push_back(bus.ram_a);
            obs_d.push_back(bus.ram_dout);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_n(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    // One whole access: model decides winner, byte count, data and the edge at which done appears.
    task automatic txn(input bit rq_if, input bit rq_ls, input bit we_i, input logic [1:0] sz,
                       input logic [31:0] a_if, input logic [31:0] a_ls, input logic [31:0] wd,
                       input int rdy_pct, input int io_n, input int io_pct,
                       input int flush_at, input int hold_at, input int hold_len,
                       output int lat);
        bit wls, wr, io, vis, abort, ended, r, f, iof;
        int n, k, wl, cyc;
        logic [31:0] a, exp_d;
        logic [31:0] wexp_a[$];
        logic [7:0]  wexp_d[$];

        bus.rdy = 1'b1; bus.flush = 1'b0; bus.io_full = 1'b0;
        bus.if_req = rq_if; bus.if_addr = a_if;
        bus.ls_req = rq_ls; bus.ls_we = we_i; bus.ls_size = sz; bus.ls_addr = a_ls; bus.ls_wdata = wd;
        #1;
        if (rq_if) chk("if_ready_idle", 32'(bus.if_ready), 32'd1);
        if (rq_ls) chk("ls_ready_idle", 32'(bus.ls_ready), 32'd1);

        wls = rq_ls && (!rq_if || !m_last_ls);
        m_last_ls = wls;
        a  = wls ? a_ls : a_if;
        n  = wls ? size_n(sz) : 4;
        wr = wls && we_i;
        io = (a & IO_MASK) == IO_MASK;
        exp_d = '0;
        for (int i = 0; i < n; i++) begin
            if (wr) begin
                mmem[idx(a + 32'(i))] = wd[8*i +: 8];
                wexp_a.push_back(a + 32'(i));
                wexp_d.push_back(wd[8*i +: 8]);
            end else begin
                exp_d[8*i +: 8] = mmem[idx(a + 32'(i))];
            end
        end
        obs_a.delete();
        obs_d.delete();

        @(posedge clk);
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        k = 0; wl = n; cyc = 0; lat = -1;
        vis = 0; abort = 0; ended = 0;
        for (int c = 0; c < 400 && !ended; c++) begin
            r = int'($urandom_range(99)) >= rdy_pct;
            if (cyc >= hold_at && cyc < hold_at + hold_len) r = 1'b0;
            f = (cyc == flush_at);
            if (f) r = 1'b1;
            iof = (cyc < io_n) || (int'($urandom_range(99)) < io_pct);
            bus.rdy = r; bus.flush = f; bus.io_full = iof;
            @(posedge clk);
            cyc++;
            if (r) begin
                if (vis) begin
                    vis = 0;
                    ended = 1;
                end else if (!wr) begin
                    if (f) begin
                        abort = 1;
                        ended = 1;
                    end else begin
                        k++;
                        if (k == n + 1) begin vis = 1; lat = cyc; end
                    end
                end else begin
                    if (wl == 0) begin vis = 1; lat = cyc; end
                    else if (!(io && iof)) wl--;
                end
            end
            @(negedge clk);
            chk("if_done", 32'(bus.if_done), 32'(vis && !wls));
            chk("ls_done", 32'(bus.ls_done), 32'(vis && wls));
            if (!wr)
                chk("ram_a", bus.ram_a, (!abort && k >= 1 && k <= n) ? a + 32'(k - 1) : 32'h0);
            if (!vis && !ended) begin
                chk("if_ready_busy", 32'(bus.if_ready), 32'd0);
                chk("ls_ready_busy", 32'(bus.ls_ready), 32'd0);
            end
            if (vis && !wr) begin
                if (wls) chk("ls_rdata", bus.ls_rdata, exp_d);
                else     chk("if_data", bus.if_data, exp_d);
            end
        end
        chk("txn_end", 32'(ended), 32'd1);
        chk("wr_count", 32'(obs_a.size()), 32'(wexp_a.size()));
        for (int i = 0; i < wexp_a.size() && i < obs_a.size(); i++) begin
            chk("wr_addr", obs_a[i], wexp_a[i]);
            chk("wr_byte", 32'(obs_d[i]), 32'(wexp_d[i]));
        end
        bus.rdy = 1'b1; bus.flush = 1'b0; bus.io_full = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        bit qi, ql, we;
        logic [1:0] sz;
        logic [31:0] ai, al, wd;
        int fa;
        logic [7:0] b;

        n_tests = 0; n_fail = 0; m_last_ls = 0;
        for (int i = 0; i < 4096; i++) begin
            b = 8'($urandom);
            ram[i] = b;
            mmem[i] = b;
        end
        ram[idx(32'h100)] = 8'h11; mmem[idx(32'h100)] = 8'h11;
        ram[idx(32'h101)] = 8'h22; mmem[idx(32'h101)] = 8'h22;
        ram[idx(32'h102)] = 8'h33; mmem[idx(32'h102)] = 8'h33;
        ram[idx(32'h103)] = 8'h44; mmem[idx(32'h103)] = 8'h44;
        ram[idx(32'h203)] = 8'hF5; mmem[idx(32'h203)] = 8'hF5;

        rst = 1'b1;
        bus.rdy = 1'b1; bus.flush = 1'b0; bus.io_full = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = 32'h203; bus.ls_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_if_ready", 32'(bus.if_ready), 32'd0);
        chk("rst_ls_ready", 32'(bus.ls_ready), 32'd0);
        chk("rst_if_done", 32'(bus.if_done), 32'd0);
        chk("rst_ls_done", 32'(bus.ls_done), 32'd0);
        chk("rst_if_data", bus.if_data, 32'h0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'h0);
        chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
        chk("rst_ram_a", bus.ram_a, 32'h0);
        chk("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        rst = 1'b0;

        txn(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 0, 0, -1, -1, 0, lat);
        chk("tp_if_latency", 32'(lat), 32'd5);
        chk("tp_if_data", bus.if_data, 32'h4433_2211);

        txn(0, 1, 0, 2'd0, 0, 32'h203, 0, 0, 0, 0, -1, -1, 0, lat);
        chk("tp_ls_byte_latency", 32'(lat), 32'd2);
        chk("tp_ls_byte_data", bus.ls_rdata, 32'h0000_00F5);

        txn(0, 1, 1, 2'd1, 0, 32'h30000, 32'h0000_BEEF, 0, 3, 0, -1, -1, 0, lat);
        chk("tp_io_store_latency", 32'(lat), 32'd6);
        txn(0, 1, 0, 2'd1, 0, 32'h30000, 0, 0, 0, 0, -1, -1, 0, lat);
        chk("tp_io_readback", bus.ls_rdata, 32'h0000_BEEF);

        txn(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 0, 0, 1, -1, 0, lat);
        chk("tp_flush_no_done", 32'(lat), 32'hFFFF_FFFF);
        txn(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 0, 0, -1, -1, 0, lat);

        txn(0, 1, 1, 2'd2, 0, 32'h140, 32'hCAFE_F00D, 0, 0, 0, 2, -1, 0, lat);
        chk("tp_flush_store_latency", 32'(lat), 32'd5);
        txn(0, 1, 0, 2'd2, 0, 32'h140, 0, 0, 0, 0, -1, -1, 0, lat);
        chk("tp_store_readback", bus.ls_rdata, 32'hCAFE_F00D);

        txn(1, 0, 0, 2'd0, 32'h100, 0, 0, 0, 0, 0, -1, 1, 3, lat);
        chk("tp_rdy_hold_latency", 32'(lat), 32'd8);
        chk("tp_rdy_hold_data", bus.if_data, 32'h4433_2211);

        // Reset in the middle of a word fetch: no done may follow.
        bus.if_addr = 32'h100; bus.if_req = 1'b1; bus.rdy = 1'b1; bus.flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.if_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ram_a", bus.ram_a, 32'h0);
        chk("midrst_if_ready", 32'(bus.if_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bus.if_done), 32'd0);
        end
        m_last_ls = 0;

        for (int i = 0; i < 4; i++) begin
            txn(1, 1, 0, 2'd2, 32'h100, 32'h200 + 32'(4 * i), 0, 0, 0, 0, -1, -1, 0, lat);
        end

        for (int t = 0; t < 150; t++) begin
            qi = 1'($urandom_range(1));
            ql = 1'($urandom_range(1));
            if (!qi && !ql) ql = 1'b1;
            we = 1'($urandom_range(1));
            sz = 2'($urandom_range(3));
            ai = 32'($urandom_range(1023));
            al = 32'($urandom_range(1023));
            if ($urandom_range(3) == 0) al = al | IO_MASK;
            wd = $urandom;
            fa = ($urandom_range(7) == 0) ? int'($urandom_range(5)) : -1;
            txn(qi, ql, we, sz, ai, al, wd, 20, 0, 30, fa, -1, 0, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
